operand_router: RTL and testbench
=================================

# operand_router

Parametrised, pipelined successor to the combinational operand multiplexers and result demultiplexers. The block picks one of `NUM_SRC` source words, plus an optional immediate, and tags it with a destination index. It buffers the result in a 2-entry skid buffer with valid/ready handshakes on both sides. On the output side it drives one-hot per-destination write strobes. It sits between register-file read ports and the ALU operand/writeback paths, giving one cycle of registered latency and full-throughput back-pressure.

## Interface
Parameters:
- `WORD_SIZE`, 8, data word width in bits.
- `NUM_SRC`, 8, number of register source words; immediate is source index `NUM_SRC`.
- `NUM_DST`, 8, number of destinations; must be at least 1.
- `SEL_W`, `$clog2(NUM_SRC+2)`, source selector width; leaves room for out-of-range codes.
- `DST_W`, `$clog2(NUM_DST+1)`, destination selector width.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `src_data` in `NUM_SRC*WORD_SIZE`: flattened sources; word k is `[k*WORD_SIZE +: WORD_SIZE]`.
- `imm` in `WORD_SIZE`: immediate word, selected when `src_sel == NUM_SRC`.
- `src_sel` in `SEL_W`: source index.
- `dst_sel` in `DST_W`: destination index.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request.
- `out_data` out `WORD_SIZE`: routed word at the buffer head.
- `out_dst` out `DST_W`: destination index at the buffer head.
- `out_valid` out 1: buffer head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_we` out `NUM_DST`: one-hot write strobe, `out_we[out_dst] = out_valid & out_ready`.
- `err_sel` out 1: sticky flag; set when an accepted request had an out-of-range source or destination.

## Operation
- Accept: a request is accepted on a rising edge with `in_valid & in_ready`. The captured word is `src_data` word `src_sel` if `src_sel < NUM_SRC`, `imm` if `src_sel == NUM_SRC`, otherwise all zeros. Out-of-range source sets `err_sel`.
- Destination: `dst_sel` is captured unchanged. If `dst_sel >= NUM_DST`, the entry still flows through the handshake. `out_we` stays all-zero for that entry (null sink) and `err_sel` is set.
- Skid buffer: a 2-entry FIFO. States are EMPTY (count 0), ONE (count 1) and FULL (count 2).
  - EMPTY: push goes to ONE.
  - ONE: push only goes to FULL; pop only goes to EMPTY; push and pop together stay in ONE.
  - FULL: pop goes to ONE; no push is possible.
- Handshake signals: `in_ready = (state != FULL)`, derived from registered state only and never combinational from `out_ready`. `out_valid = (state != EMPTY)`.
- Head stability: while `out_valid & !out_ready`, `out_data` and `out_dst` hold stable.
- Pop: a pop occurs on `out_valid & out_ready`.
- Clearing `err_sel`: only `rst` clears it.
- Reset (asynchronous, any time): state goes to EMPTY. `out_valid`, `out_data`, `out_dst`, `out_we` and `err_sel` all go to 0. `in_ready` goes to 1 after reset releases. In-flight entries are discarded with no strobe.

## Timing
- Latency: a request accepted at edge N appears with `out_valid=1` after edge N and can be written at edge N+1.
- Throughput: one transfer per cycle with `out_ready` held high.
- Stall: `out_ready` low for 2+ cycles fills the buffer, and `in_ready` falls after the second accept. The first `out_ready` cycle then reopens `in_ready` on the next cycle.
- Strobe: `out_we` is combinational from registered head state and `out_ready`, with no extra register.

## Structure
- Package `tau_route_pkg`:
  - `route_state_t` enum (EMPTY, ONE, FULL).
  - `route_entry_t` struct (`data`, `dst`).
  - Function `onehot_dst(dst, n)` that returns zero when out of range.
- Sub-module `route_skid_buffer`:
  - Generic 2-entry valid/ready buffer of `route_entry_t`.
  - Holds the state machine.
- Top-level `operand_router`:
  - Holds the selection logic, error flag and strobe decode.

## Test plan
- Reset mid-stream: FULL with two entries, assert `rst` asynchronously -> `out_valid=0`, `out_we=0`, `err_sel=0` immediately; no write strobe for the discarded entries.
- Basic route: `src_sel=3` with word3=`0xA5`, `dst_sel=5`, `out_ready=1` -> next cycle `out_data=0xA5`, `out_dst=5`, `out_we=8'b0010_0000`.
- Immediate and out-of-range source: `src_sel=8` with `imm=0x3C` -> `out_data=0x3C`. Then `src_sel=9` -> `out_data=0x00` and `err_sel=1`, staying 1.
- Null destination: defaults with `DST_W=4`, `dst_sel=9` -> `out_valid=1`, `out_we=0`, `err_sel=1`; the entry pops normally.
- Back-pressure: 4 back-to-back requests with `out_ready=0` -> `in_ready` goes 0 after 2 accepts. Release `out_ready` -> outputs in order with no loss or duplication, one per cycle.

Source files
------------

// File: rtl/tau_route_pkg.sv
// Shared types and helpers for the operand router: buffer state, buffered entry
// and the destination one-hot decode.
package tau_route_pkg;

   localparam int unsigned ROUTE_WORD_SIZE = 8;
   localparam int unsigned ROUTE_DST_W     = 4;
   localparam int unsigned ROUTE_MAX_DST   = 64;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} route_state_t;

   typedef struct packed {
      logic [ROUTE_WORD_SIZE-1:0] data;
      logic [ROUTE_DST_W-1:0]     dst;
   } route_entry_t;

   // Out-of-range destinations decode to no strobe at all (null sink).
   function automatic logic [ROUTE_MAX_DST-1:0] onehot_dst(input int unsigned dst,
                                                          input int unsigned n);
      logic [ROUTE_MAX_DST-1:0] one;
      one = {{(ROUTE_MAX_DST-1){1'b0}}, 1'b1};
      if (dst < n && dst < ROUTE_MAX_DST) return one << dst;
      return '0;
   endfunction

endpackage

// File: rtl/operand_router_if.sv
// Request/response bundle between register-file read ports, the router and the
// ALU operand/writeback consumer.
interface operand_router_if #(
   parameter int unsigned WORD_SIZE = 8,
   parameter int unsigned NUM_SRC   = 8,
   parameter int unsigned NUM_DST   = 8,
   parameter int unsigned SEL_W     = $clog2(NUM_SRC + 2),
   parameter int unsigned DST_W     = $clog2(NUM_DST + 1)
) ();

   logic [NUM_SRC*WORD_SIZE-1:0] src_data;
   logic [WORD_SIZE-1:0]         imm;
   logic [SEL_W-1:0]             src_sel;
   logic [DST_W-1:0]             dst_sel;
   logic                         in_valid;
   logic                         in_ready;
   logic [WORD_SIZE-1:0]         out_data;
   logic [DST_W-1:0]             out_dst;
   logic                         out_valid;
   logic                         out_ready;
   logic [NUM_DST-1:0]           out_we;
   logic                         err_sel;

   modport master (
      output src_data, imm, src_sel, dst_sel, in_valid, out_ready,
      input  in_ready, out_data, out_dst, out_valid, out_we, err_sel
   );

   modport slave (
      input  src_data, imm, src_sel, dst_sel, in_valid, out_ready,
      output in_ready, out_data, out_dst, out_valid, out_we, err_sel
   );

endinterface

// File: rtl/route_skid_buffer.sv
// Two-entry valid/ready buffer. in_ready depends only on registered state so the
// upstream never sees a combinational path from out_ready.
module route_skid_buffer
   import tau_route_pkg::*;
#(
   parameter type entry_t = route_entry_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   in_valid,
   output logic   in_ready,
   input  entry_t in_entry,
   output logic   out_valid,
   input  logic   out_ready,
   output entry_t out_entry
);

   route_state_t state_q, state_d;
   entry_t       head_q, tail_q;
   logic         push, pop;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY:   if (push) state_d = ONE;
         ONE: begin
            if (push && !pop)      state_d = FULL;
            else if (!push && pop) state_d = EMPTY;
         end
         FULL:    if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      in_ready  = (state_q != FULL);
      out_valid = (state_q != EMPTY);
      out_entry = head_q;
   end

   // Head always holds the oldest entry; tail is only used while FULL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         unique case (state_q)
            EMPTY: if (push) head_q <= in_entry;
            ONE: begin
               if (push && pop) head_q <= in_entry;
               else if (push)   tail_q <= in_entry;
            end
            FULL:  if (pop) head_q <= tail_q;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/operand_router.sv
// Selects a source word or the immediate, tags it with a destination and hands it
// through a skid buffer; decodes per-destination write strobes at the head.
module operand_router
   import tau_route_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 8,
   parameter int unsigned NUM_SRC   = 8,
   parameter int unsigned NUM_DST   = 8,
   parameter int unsigned SEL_W     = $clog2(NUM_SRC + 2),
   parameter int unsigned DST_W     = $clog2(NUM_DST + 1)
) (
   input logic              clk,
   input logic              rst,
   operand_router_if.slave  bus
);

   typedef struct packed {
      logic [WORD_SIZE-1:0] data;
      logic [DST_W-1:0]     dst;
   } entry_t;

   entry_t               in_entry, out_entry;
   logic [WORD_SIZE-1:0] sel_word;
   logic                 src_bad, dst_bad, accept;
   logic                 err_q;

   // Codes above NUM_SRC select nothing and leave the word at zero.
   always_comb begin
      sel_word = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (bus.src_sel == SEL_W'(k)) sel_word = bus.src_data[k*WORD_SIZE +: WORD_SIZE];
      end
      if (bus.src_sel == SEL_W'(NUM_SRC)) sel_word = bus.imm;
   end

   assign src_bad       = (bus.src_sel > SEL_W'(NUM_SRC));
   assign dst_bad       = (bus.dst_sel >= DST_W'(NUM_DST));
   assign accept        = bus.in_valid & bus.in_ready;
   assign in_entry.data = sel_word;
   assign in_entry.dst  = bus.dst_sel;

   route_skid_buffer #(
      .entry_t (entry_t)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_entry  (in_entry),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_entry (out_entry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             err_q <= 1'b0;
      else if (accept && (src_bad || dst_bad)) err_q <= 1'b1;
   end

   assign bus.err_sel  = err_q;
   assign bus.out_data = out_entry.data;
   assign bus.out_dst  = out_entry.dst;
   assign bus.out_we   = NUM_DST'(onehot_dst(int'(out_entry.dst), NUM_DST))
                         & {NUM_DST{bus.out_valid & bus.out_ready}};

endmodule

// File: tb/tb_operand_router.sv
// Directed bench for operand_router: routing, immediate, bad selectors,
// back-pressure ordering and asynchronous reset of a full buffer.
module tb_operand_router;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   operand_router_if bus ();

   operand_router dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic v, input logic [3:0] src, input logic [3:0] dst);
      bus.in_valid = v;
      bus.src_sel  = src;
      bus.dst_sel  = dst;
   endtask

   initial begin
      rst           = 1'b1;
      bus.src_data  = {8'h88, 8'h77, 8'h66, 8'h55, 8'hA5, 8'h33, 8'h22, 8'h11};
      bus.imm       = 8'h3C;
      bus.out_ready = 1'b0;
      req(1'b0, 4'd0, 4'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_we", bus.out_we, 0);
      check("rst_err", bus.err_sel, 0);

      // Basic route: word3 -> dst 5
      bus.out_ready = 1'b1;
      req(1'b1, 4'd3, 4'd5);
      tick();
      req(1'b0, 4'd0, 4'd0);
      #1;
      check("basic_valid", bus.out_valid, 1);
      check("basic_data", bus.out_data, 8'hA5);
      check("basic_dst", bus.out_dst, 5);
      check("basic_we", bus.out_we, 8'b0010_0000);
      check("basic_err", bus.err_sel, 0);
      tick();
      check("basic_popped", bus.out_valid, 0);

      // Immediate then out-of-range source, back to back
      req(1'b1, 4'd8, 4'd0);
      tick();
      check("imm_data", bus.out_data, 8'h3C);
      check("imm_we", bus.out_we, 8'h01);
      check("imm_err", bus.err_sel, 0);
      req(1'b1, 4'd9, 4'd1);
      tick();
      req(1'b0, 4'd0, 4'd0);
      #1;
      check("badsrc_data", bus.out_data, 8'h00);
      check("badsrc_dst", bus.out_dst, 1);
      check("badsrc_err", bus.err_sel, 1);
      tick();
      tick();
      check("badsrc_drained", bus.out_valid, 0);
      check("err_sticky", bus.err_sel, 1);

      // Back-pressure: four requests, consumer stalled
      bus.out_ready = 1'b0;
      req(1'b1, 4'd0, 4'd0);
      #1;
      check("bp_ready0", bus.in_ready, 1);
      tick();
      check("bp_ready1", bus.in_ready, 1);
      check("bp_valid1", bus.out_valid, 1);
      check("bp_we_stall", bus.out_we, 0);
      req(1'b1, 4'd1, 4'd1);
      tick();
      check("bp_full", bus.in_ready, 0);
      check("bp_head0", bus.out_data, 8'h11);
      req(1'b1, 4'd2, 4'd2);
      tick();
      check("bp_still_full", bus.in_ready, 0);
      check("bp_head_stable", bus.out_data, 8'h11);
      check("bp_dst_stable", bus.out_dst, 0);
      bus.out_ready = 1'b1;
      #1;
      check("bp_we0", bus.out_we, 8'h01);
      check("bp_ready_comb", bus.in_ready, 0);
      tick();
      check("bp_reopen", bus.in_ready, 1);
      check("bp_head1", bus.out_data, 8'h22);
      check("bp_we1", bus.out_we, 8'h02);
      tick();
      check("bp_head2", bus.out_data, 8'h33);
      check("bp_we2", bus.out_we, 8'h04);
      req(1'b1, 4'd4, 4'd7);
      tick();
      req(1'b0, 4'd0, 4'd0);
      #1;
      check("bp_head3", bus.out_data, 8'h55);
      check("bp_we3", bus.out_we, 8'h80);
      tick();
      check("bp_drained", bus.out_valid, 0);

      // Reset mid-stream with the buffer full
      bus.out_ready = 1'b0;
      req(1'b1, 4'd5, 4'd3);
      tick();
      req(1'b1, 4'd6, 4'd6);
      tick();
      req(1'b0, 4'd0, 4'd0);
      check("mid_full", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      #1;
      check("mid_valid", bus.out_valid, 0);
      check("mid_we", bus.out_we, 0);
      check("mid_err", bus.err_sel, 0);
      check("mid_data", bus.out_data, 0);
      tick();
      check("mid_we_hold", bus.out_we, 0);
      rst = 1'b0;
      #1;
      check("mid_in_ready", bus.in_ready, 1);
      tick();
      check("mid_no_ghost", bus.out_valid, 0);

      // Null destination
      bus.out_ready = 1'b0;
      req(1'b1, 4'd1, 4'd9);
      tick();
      req(1'b0, 4'd0, 4'd0);
      #1;
      check("null_valid", bus.out_valid, 1);
      check("null_dst", bus.out_dst, 9);
      check("null_err", bus.err_sel, 1);
      bus.out_ready = 1'b1;
      #1;
      check("null_we", bus.out_we, 0);
      tick();
      check("null_popped", bus.out_valid, 0);
      check("null_err_sticky", bus.err_sel, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
